fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: AW, 32, width of instruction word address.
REQ-002 Parameter: DW, 32, width of instruction word.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  reset, synchronous, active-low.
REQ-005 Port: pc_in  input  AW  current program-counter value (word address).
REQ-006 Port: pc_adv  output  1  one-cycle pulse telling the program counter to advance.
REQ-007 Port: imem_req  output  1  instruction-memory request.
REQ-008 Port: imem_addr  output  AW  request address.
REQ-009 Port: imem_ack  input  1  memory response strobe, variable latency, ≥0 cycles after imem_req.
REQ-010 Port: imem_rdata  input  DW  instruction data, valid when imem_ack=1.
REQ-011 Port: flush  input  1  discard in-flight and buffered fetch.
REQ-012 Port: if_valid  output  1  if_pc/if_instr hold a fetched instruction.
REQ-013 Port: if_ready  input  1  decode stage accepts.
REQ-014 Port: if_pc  output  AW  address of delivered instruction.
REQ-015 Port: if_instr  output  DW  delivered instruction.
REQ-016 Port: fetch_cnt  output  32  count of instructions accepted by decode.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, HOLD, DRAIN, all transitions on rising clock.
REQ-018 IDLE: next cycle -> WAIT; imem_addr<=pc_in, imem_req<=1.
REQ-019 WAIT: imem_req and imem_addr SHALL stay constant until the cycle imem_ack=1.
REQ-020 WAIT, imem_ack=1, flush=0: pc_adv=1 in that cycle (combinational); next edge if_instr<=imem_rdata, if_pc<=imem_addr, if_valid<=1, imem_req<=0, -> HOLD.
REQ-021 pc_adv SHALL be high only in the REQ-020 cycle; never on a drained or flushed response.
REQ-022 HOLD: if_valid, if_pc, if_instr stable until if_ready=1.
REQ-023 HOLD, if_ready=1, flush=0: next edge if_valid<=0, fetch_cnt<=fetch_cnt+1, imem_addr<=pc_in, imem_req<=1, -> WAIT.
REQ-024 fetch_cnt SHALL wrap 0xFFFFFFFF -> 0; no saturation.
REQ-025 flush in IDLE or HOLD: next edge if_valid<=0, -> IDLE; fetch_cnt unchanged even if if_ready=1 same cycle.
REQ-026 flush in WAIT with imem_ack=0: -> DRAIN; imem_req held high until ack.
REQ-027 flush in WAIT with imem_ack=1: data discarded, imem_req<=0, -> IDLE.
REQ-028 DRAIN: on imem_ack=1 data discarded, imem_req<=0, -> IDLE; flush in DRAIN has no extra effect.
REQ-029 Minimum cycles per delivered instruction with zero-latency ack and if_ready=1: 2 (WAIT, HOLD).

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, fetch_cnt=0, pc_adv=0, from any state including WAIT/DRAIN mid-request.
REQ-031 Reset SHALL take priority over flush, imem_ack and if_ready.

Verification
REQ-032 Release reset, pc_in=0, ack 0-latency, if_ready=1 -> imem_addr 0,1,2,... every 2 cycles; pc_adv one pulse each; fetch_cnt increments per delivery.
REQ-033 Ack latency 3 cycles, pc_in=0x10 -> imem_req high 4 cycles, addr 0x10 stable; if_pc=0x10, if_instr=rdata.
REQ-034 if_ready=0 for 5 cycles in HOLD -> outputs stable, no new imem_req, no pc_adv.
REQ-035 flush in WAIT, ack 2 cycles later -> DRAIN, req held until ack, no pc_adv, if_valid stays 0, then IDLE.
REQ-036 reset=0 asserted in WAIT -> next edge imem_req=0, all outputs 0; fetch_cnt preset 0xFFFFFFFF, one delivery -> 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one request at a time to instruction memory and
// hands the fetched word to decode over a valid/ready pair; flush drops in-flight work.
module fetch_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    output logic          pc_adv,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    input  logic          flush,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [AW-1:0] if_pc,
    output logic [DW-1:0] if_instr,
    output logic [31:0]   fetch_cnt,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            imem_req_q, imem_req_d;
    logic [AW-1:0]   imem_addr_q, imem_addr_d;
    logic            if_valid_q, if_valid_d;
    logic [AW-1:0]   if_pc_q, if_pc_d;
    logic [DW-1:0]   if_instr_q, if_instr_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;

    // Decode handshake: an instruction transfers on a cycle with if_valid=1 and
    // if_ready=1; while if_valid=1 and if_ready=0 the if_* outputs hold still.
    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        fetch_cnt_d = fetch_cnt_q;
        pc_adv      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    if_valid_d = 1'b0;
                end else begin
                    imem_addr_d = pc_in;
                    imem_req_d  = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        // Reset wins over a same-cycle response, so the PC is not told to move.
                        pc_adv     = reset;
                        if_instr_d = imem_rdata;
                        if_pc_d    = imem_addr_q;
                        if_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (flush) begin
                    if_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (if_ready) begin
                    if_valid_d  = 1'b0;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    imem_addr_d = pc_in;
                    imem_req_d  = 1'b1;
                    state_d     = WAIT;
                end
            end
            DRAIN: begin
                // The memory still owes a response; keep requesting until it arrives, then drop it.
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign fetch_cnt = fetch_cnt_q;
    assign state_dbg = state_q;

endmodule
